regfile_writeback_queue: RTL and testbench
==========================================

// Module: regfile_writeback_queue
// PURPOSE
//  Write-side initiator for the 8x8 register file: buffers results from ALU and load unit,
//  arbitrates them into one write stream, drives regwrite/write_address/write_data.
//  Sits between execute/memory stages and the register file write port.
//  Also exports a pending-write scoreboard, so decode can stall on RAW hazards against queued writes.
// PARAMETERS
//  DATA_W  8  result / register width
//  ADDR_W  3  register address width (8 registers)
//  DEPTH   4  queue entries; power of 2, >=2
// PORTS
//  clk               in   1       clock
//  rst               in   1       synchronous reset, active-high
//  alu_valid         in   1       ALU result valid
//  alu_ready         out  1       ALU result accepted this cycle
//  alu_addr          in   ADDR_W  ALU destination register
//  alu_data          in   DATA_W  ALU result
//  mem_valid         in   1       load result valid
//  mem_ready         out  1       load result accepted this cycle
//  mem_addr          in   ADDR_W  load destination register
//  mem_data          in   DATA_W  load data
//  rf_grant          in   1       register file write port available this cycle
//  rf_regwrite       out  1       write strobe to register file (registered)
//  rf_write_address  out  ADDR_W  write address (registered)
//  rf_write_data     out  DATA_W  write data (registered)
//  rd, rs            in   ADDR_W  decode-stage read addresses to check
//  busy_rd, busy_rs  out  1       pending write exists for rd / rs
//  fwd_rd_valid/fwd_rs_valid  out  1       forward hit (WB_BYPASS_EN only)
//  fwd_rd_data/fwd_rs_data    out  DATA_W  forwarded value (WB_BYPASS_EN only)
//  count             out  $clog2(DEPTH)+1  occupied entries
//  full, empty       out  1       count==DEPTH / count==0
// BEHAVIOUR
//  - Reset: queue cleared, pointers 0, rf_regwrite=0, rf_write_address=0, rf_write_data=0, count=0, empty=1,
//    full=0, busy_*=0, fwd_*=0. Reset mid-operation drops all queued entries and any in-flight write.
//  - Enqueue: max one entry per cycle.
//    - Load has fixed priority: mem_ready = !full.
//    - alu_ready = !full && !mem_valid.
//    - A transfer occurs on a clock edge where valid && ready.
//  - Dequeue: on an edge with !empty && rf_grant, pop head into the rf_* output register and set rf_regwrite=1.
//    Otherwise rf_regwrite=0 next cycle; address/data hold their last value.
//  - Latency: entry enqueued at edge N into an empty queue with rf_grant=1 -> rf_regwrite high after edge N+1
//    -> register file updated at edge N+2.
//  - Simultaneous push and pop: allowed; count unchanged.
//    When full, a pop does not enable a push in the same cycle (ready uses registered full).
//  - Ordering: strict FIFO; pointers wrap modulo DEPTH; same-address entries retire in order.
//  - Address 0 is an ordinary register: writes to it pass through unchanged.
//  - Scoreboard (combinational): busy_rd = any valid queue entry with addr==rd, OR (rf_regwrite && rf_write_address==rd).
//    busy_rs is the same check against rs.
//  - No data width conversion; data passed bit-exact.
// CONFIGURATION
//  - WB_BYPASS_EN defined: fwd_rd_valid=busy_rd. fwd_rd_data = data of the youngest matching entry
//    (queue entries searched tail->head, then the output register). Same for rs. Decode may consume the forwarded value
//    instead of stalling.
//  - Undefined: fwd_* outputs tied to 0; no search logic.
// TESTING
//  - Reset, single ALU push r3=0x5A, rf_grant=1 -> rf_regwrite 1 cycle, addr=3, data=0x5A, 2 edges after accept.
//  - Simultaneous alu_valid/mem_valid (r1=0x11 / r2=0x22) -> mem first, alu_ready=0 that cycle; writes r2 then r1.
//  - rf_grant=0, push 4 entries -> full=1, count=4, ready=0; 5th held; grant=1 drains in order, then accepts 5th.
//  - Pushes to r5 (0xAA then 0xBB), rd=5 -> busy_rd=1 until second write retires; WB_BYPASS_EN: fwd_rd_data=0xBB.
//  - Continuous push+pop for 10 entries -> pointer wrap, count stable at 1, data order preserved.
//  - rst asserted with 3 entries queued -> next cycle empty=1, rf_regwrite=0, no further writes issued.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// Write-back queue for the 8x8 register file: merges ALU and load results into one FIFO,
// retires them through a registered write port, and exposes a pending-write scoreboard.
// Optional forwarding of the youngest pending value is enabled by defining WB_BYPASS_EN.
module regfile_writeback_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_addr,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic                       rf_grant,
  output logic                       rf_regwrite,
  output logic [ADDR_W-1:0]          rf_write_address,
  output logic [DATA_W-1:0]          rf_write_data,
  input  logic [ADDR_W-1:0]          rd,
  input  logic [ADDR_W-1:0]          rs,
  output logic                       busy_rd,
  output logic                       busy_rs,
  output logic                       fwd_rd_valid,
  output logic                       fwd_rs_valid,
  output logic [DATA_W-1:0]          fwd_rd_data,
  output logic [DATA_W-1:0]          fwd_rs_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Handshake: a source transfers on any rising edge where its valid and ready are both high;
  // ready depends only on registered occupancy and mem_valid, never on the same-cycle pop,
  // so a full queue refuses input even while it drains. Loads always win over ALU results.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign push    = !full && (mem_valid || alu_valid);
  assign pop     = !empty && rf_grant;
  assign in_addr = mem_valid ? mem_addr : alu_addr;
  assign in_data = mem_valid ? mem_data : alu_data;

  // Queue storage carries no reset; occupancy is tracked solely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= in_addr;
      q_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      rf_regwrite      <= 1'b0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr           <= rd_ptr + 1'b1;
        rf_regwrite      <= 1'b1;
        rf_write_address <= q_addr[rd_ptr];
        rf_write_data    <= q_data[rd_ptr];
      end else begin
        rf_regwrite <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  // Returns {hit, data}; walking head->tail lets later (younger) matches override older ones,
  // and the output register is the oldest candidate of all.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
    logic              hit;
    logic [DATA_W-1:0] d;
    logic [PTR_W-1:0]  idx;
    hit = rf_regwrite && (rf_write_address == a);
    d   = rf_write_data;
    idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((i < int'(count)) && (q_addr[idx] == a)) begin
        hit = 1'b1;
        d   = q_data[idx];
      end
    end
    return {hit, d};
  endfunction

  logic [DATA_W:0] look_rd;
  logic [DATA_W:0] look_rs;

  assign look_rd      = lookup(rd);
  assign look_rs      = lookup(rs);
  assign busy_rd      = look_rd[DATA_W];
  assign busy_rs      = look_rs[DATA_W];
  assign fwd_rd_valid = look_rd[DATA_W];
  assign fwd_rs_valid = look_rs[DATA_W];
  assign fwd_rd_data  = look_rd[DATA_W] ? look_rd[DATA_W-1:0] : '0;
  assign fwd_rs_data  = look_rs[DATA_W] ? look_rs[DATA_W-1:0] : '0;
`else
  function automatic logic pending(input logic [ADDR_W-1:0] a);
    logic             hit;
    logic [PTR_W-1:0] idx;
    hit = rf_regwrite && (rf_write_address == a);
    idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((i < int'(count)) && (q_addr[idx] == a)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  assign busy_rd      = pending(rd);
  assign busy_rs      = pending(rs);
  assign fwd_rd_valid = 1'b0;
  assign fwd_rs_valid = 1'b0;
  assign fwd_rd_data  = '0;
  assign fwd_rs_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: hand-computed expectations checked with
// immediate assertions after each clock step.
module tb_regfile_writeback_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_valid, alu_ready;
  logic [2:0] alu_addr;
  logic [7:0] alu_data;
  logic       mem_valid, mem_ready;
  logic [2:0] mem_addr;
  logic [7:0] mem_data;
  logic       rf_grant;
  logic       rf_regwrite;
  logic [2:0] rf_write_address;
  logic [7:0] rf_write_data;
  logic [2:0] rd, rs;
  logic       busy_rd, busy_rs;
  logic       fwd_rd_valid, fwd_rs_valid;
  logic [7:0] fwd_rd_data, fwd_rs_data;
  logic [2:0] count;
  logic       full, empty;

  int tests  = 0;
  int failed = 0;

  regfile_writeback_queue dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_grant(rf_grant), .rf_regwrite(rf_regwrite),
    .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
    .rd(rd), .rs(rs), .busy_rd(busy_rd), .busy_rs(busy_rs),
    .fwd_rd_valid(fwd_rd_valid), .fwd_rs_valid(fwd_rs_valid),
    .fwd_rd_data(fwd_rd_data), .fwd_rs_data(fwd_rs_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 2 time units before driving or checking.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic alu_push(input logic [2:0] a, input logic [7:0] d);
    alu_valid = 1'b1;
    alu_addr  = a;
    alu_data  = d;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rf_grant = 1'b0; rd = 3'd0; rs = 3'd0;
    alu_valid = 1'b0; alu_addr = 3'd0; alu_data = 8'h00;
    mem_valid = 1'b0; mem_addr = 3'd0; mem_data = 8'h00;

    // Reset state
    tick(); tick();
    chk("rst_regwrite", 32'(rf_regwrite), 32'd0);
    chk("rst_addr", 32'(rf_write_address), 32'd0);
    chk("rst_data", 32'(rf_write_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy_rd", 32'(busy_rd), 32'd0);
    chk("rst_fwd_rd", 32'({fwd_rd_valid, fwd_rd_data}), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    rst = 1'b0;

    // Single ALU push r3=0x5A with grant: write appears after the second edge
    rf_grant = 1'b1; rd = 3'd3;
    alu_push(3'd3, 8'h5A);
    #1 chk("a_alu_ready", 32'(alu_ready), 32'd1);
    tick(); idle_inputs();
    chk("a_count1", 32'(count), 32'd1);
    chk("a_no_write_yet", 32'(rf_regwrite), 32'd0);
    chk("a_busy_queued", 32'(busy_rd), 32'd1);
    tick();
    chk("a_regwrite", 32'(rf_regwrite), 32'd1);
    chk("a_addr", 32'(rf_write_address), 32'd3);
    chk("a_data", 32'(rf_write_data), 32'h5A);
    chk("a_busy_outreg", 32'(busy_rd), 32'd1);
    chk("a_empty", 32'(empty), 32'd1);
    tick();
    chk("a_regwrite_low", 32'(rf_regwrite), 32'd0);
    chk("a_addr_hold", 32'(rf_write_address), 32'd3);
    chk("a_busy_clear", 32'(busy_rd), 32'd0);

    // ALU r1=0x11 and load r2=0x22 together: load goes first
    alu_push(3'd1, 8'h11);
    mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 8'h22;
    #1 chk("b_alu_ready0", 32'(alu_ready), 32'd0);
    chk("b_mem_ready1", 32'(mem_ready), 32'd1);
    tick(); mem_valid = 1'b0;
    #1 chk("b_alu_ready1", 32'(alu_ready), 32'd1);
    tick(); idle_inputs();
    chk("b_first_addr", 32'(rf_write_address), 32'd2);
    chk("b_first_data", 32'(rf_write_data), 32'h22);
    chk("b_count", 32'(count), 32'd1);
    tick();
    chk("b_second_we", 32'(rf_regwrite), 32'd1);
    chk("b_second_addr", 32'(rf_write_address), 32'd1);
    chk("b_second_data", 32'(rf_write_data), 32'h11);
    tick();
    chk("b_idle", 32'(rf_regwrite), 32'd0);

    // Fill with grant low, hold a fifth entry, then drain in order
    rf_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alu_push(3'(i + 4), 8'(8'hC0 + i));
      tick();
    end
    alu_push(3'd0, 8'h99);
    #1 chk("c_full", 32'(full), 32'd1);
    chk("c_count4", 32'(count), 32'd4);
    chk("c_alu_ready0", 32'(alu_ready), 32'd0);
    chk("c_mem_ready0", 32'(mem_ready), 32'd0);
    tick(); tick();
    chk("c_held_count", 32'(count), 32'd4);
    chk("c_held_nowrite", 32'(rf_regwrite), 32'd0);
    rf_grant = 1'b1;
    tick();
    chk("c_drain0_addr", 32'(rf_write_address), 32'd4);
    chk("c_drain0_data", 32'(rf_write_data), 32'hC0);
    chk("c_count3", 32'(count), 32'd3);
    chk("c_alu_ready1", 32'(alu_ready), 32'd1);
    tick(); idle_inputs();
    chk("c_drain1_data", 32'(rf_write_data), 32'hC1);
    chk("c_pushpop_count", 32'(count), 32'd3);
    for (int i = 2; i < 4; i++) begin
      tick();
      chk("c_drain_addr", 32'(rf_write_address), 32'(i + 4));
      chk("c_drain_data", 32'(rf_write_data), 32'(8'hC0 + i));
    end
    tick();
    chk("c_fifth_addr0", 32'(rf_write_address), 32'd0);
    chk("c_fifth_data", 32'(rf_write_data), 32'h99);
    chk("c_fifth_we", 32'(rf_regwrite), 32'd1);
    tick();
    chk("c_empty", 32'(empty), 32'd1);

    // Two pending writes to r5: busy until the second retires, forward the younger
    rf_grant = 1'b0; rd = 3'd5; rs = 3'd4;
    alu_push(3'd5, 8'hAA); tick();
    alu_push(3'd5, 8'hBB); tick(); idle_inputs();
    #1 chk("d_busy_rd", 32'(busy_rd), 32'd1);
    chk("d_busy_rs", 32'(busy_rs), 32'd0);
`ifdef WB_BYPASS_EN
    chk("d_fwd_valid", 32'(fwd_rd_valid), 32'd1);
    chk("d_fwd_data", 32'(fwd_rd_data), 32'hBB);
`else
    chk("d_fwd_off", 32'({fwd_rd_valid, fwd_rd_data}), 32'd0);
`endif
    rf_grant = 1'b1;
    tick();
    chk("d_first_data", 32'(rf_write_data), 32'hAA);
    chk("d_busy_after1", 32'(busy_rd), 32'd1);
`ifdef WB_BYPASS_EN
    chk("d_fwd_after1", 32'(fwd_rd_data), 32'hBB);
`endif
    tick();
    chk("d_second_data", 32'(rf_write_data), 32'hBB);
    chk("d_busy_outreg", 32'(busy_rd), 32'd1);
    tick();
    chk("d_busy_clear", 32'(busy_rd), 32'd0);

    // Continuous push+pop across pointer wrap
    for (int k = 0; k < 10; k++) begin
      alu_push(3'(k), 8'(8'h30 + k));
      tick();
      chk("e_count", 32'(count), 32'd1);
      if (k >= 1) begin
        chk("e_we", 32'(rf_regwrite), 32'd1);
        chk("e_data", 32'(rf_write_data), 32'(8'h30 + k - 1));
        chk("e_addr", 32'(rf_write_address), 32'((k - 1) % 8));
      end
    end
    idle_inputs();
    tick();
    chk("e_last_data", 32'(rf_write_data), 32'h39);
    chk("e_last_count", 32'(count), 32'd0);
    tick();

    // Reset with three queued entries and a write in flight
    rf_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_push(3'(i + 1), 8'(8'h70 + i));
      tick();
    end
    idle_inputs();
    rf_grant = 1'b1;
    tick();
    chk("f_inflight", 32'(rf_regwrite), 32'd1);
    chk("f_count2", 32'(count), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("f_empty", 32'(empty), 32'd1);
    chk("f_we_dropped", 32'(rf_regwrite), 32'd0);
    chk("f_addr_reset", 32'(rf_write_address), 32'd0);
    tick(); tick();
    chk("f_no_more_writes", 32'(rf_regwrite), 32'd0);
    chk("f_count0", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
